// File: rtl/inst_fetch_ctrl.sv
// Instruction-fetch sequencer: owns fetch_pc, waits MEM_WAIT cycles per word,
// and buffers returned words in a 2-entry prefetch queue feeding IF/ID.
module inst_fetch_ctrl #(
    parameter int MEM_WAIT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_inst,
    output logic        inst_valid,
    output logic [31:0] inst_out,
    output logic [31:0] pc_out,
    output logic [1:0]  q_count
);

    // state   | meaning
    // S_WAIT  | memory still settling on mem_addr (wcnt < MEM_WAIT)
    // S_READY | mem_inst valid; capture it if the queue has room
    // S_FULL  | word valid but queue full and not draining; hold fetch_pc
    typedef enum logic [1:0] {
        S_WAIT  = 2'd0,
        S_READY = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    localparam logic [3:0] MW      = 4'(MEM_WAIT);
    localparam state_t     ST_IDLE = (MEM_WAIT == 0) ? S_READY : S_WAIT;

    state_t      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [3:0]  wcnt_q, wcnt_d;
    logic [31:0] q_pc_q [0:1];
    logic [31:0] q_pc_d [0:1];
    logic [31:0] q_inst_q [0:1];
    logic [31:0] q_inst_d [0:1];
    logic        head_q, head_d;
    logic        tail_q, tail_d;
    logic [1:0]  count_q, count_d;

    logic        pop;
    logic        push;
    logic        space;
    logic        ready;

    always_comb begin
        pop   = (count_q != 2'd0) && !freeze;
        space = (count_q != 2'd2) || pop;
        ready = (state_q != S_WAIT);
        push  = ready && space;

        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        wcnt_d      = wcnt_q;
        q_pc_d[0]   = q_pc_q[0];
        q_pc_d[1]   = q_pc_q[1];
        q_inst_d[0] = q_inst_q[0];
        q_inst_d[1] = q_inst_q[1];
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;

        if (branch_taken) begin
            // redirect discards the queue and any same-cycle push/pop
            count_d    = 2'd0;
            head_d     = 1'b0;
            tail_d     = 1'b0;
            fetch_pc_d = branch_addr & 32'hFFFF_FFFC;
            wcnt_d     = 4'd0;
            state_d    = ST_IDLE;
        end else begin
            if (pop) begin
                head_d = ~head_q;
            end

            if (push) begin
                q_pc_d[tail_q]   = fetch_pc_q;
                q_inst_d[tail_q] = mem_inst;
                tail_d           = ~tail_q;
                fetch_pc_d       = fetch_pc_q + 32'd4;
                wcnt_d           = 4'd0;
            end

            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase

            case (state_q)
                S_WAIT: begin
                    wcnt_d = wcnt_q + 4'd1;
                    if (wcnt_q + 4'd1 == MW) begin
                        state_d = S_READY;
                    end
                end
                S_READY, S_FULL: begin
                    // no push while ready only happens with a full, frozen queue
                    if (push) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = S_FULL;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    wcnt_d  = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            fetch_pc_q  <= 32'd0;
            wcnt_q      <= 4'd0;
            q_pc_q[0]   <= 32'd0;
            q_pc_q[1]   <= 32'd0;
            q_inst_q[0] <= 32'd0;
            q_inst_q[1] <= 32'd0;
            head_q      <= 1'b0;
            tail_q      <= 1'b0;
            count_q     <= 2'd0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            wcnt_q      <= wcnt_d;
            q_pc_q[0]   <= q_pc_d[0];
            q_pc_q[1]   <= q_pc_d[1];
            q_inst_q[0] <= q_inst_d[0];
            q_inst_q[1] <= q_inst_d[1];
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
        end
    end

    always_comb begin
        mem_addr   = fetch_pc_q;
        inst_valid = (count_q != 2'd0);
        q_count    = count_q;
        inst_out   = 32'd0;
        pc_out     = 32'd0;
        if (inst_valid) begin
            inst_out = q_inst_q[head_q];
            pc_out   = q_pc_q[head_q] + 32'd4;
        end
    end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Bench for inst_fetch_ctrl: two instances (MEM_WAIT 0 and 3) share stimulus and
// are compared every cycle against a queue-level reference model.
module tb_inst_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;

    logic [31:0] mem_addr0, mem_inst0, inst_out0, pc_out0;
    logic        inst_valid0;
    logic [1:0]  q_count0;
    logic [31:0] mem_addr3, mem_inst3, inst_out3, pc_out3;
    logic        inst_valid3;
    logic [1:0]  q_count3;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        if (a == 32'd0) return 32'hE492_3002;
        else if (a < 32'd16) return 32'd0;
        else return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    assign mem_inst0 = rom(mem_addr0);
    assign mem_inst3 = rom(mem_addr3);

    inst_fetch_ctrl #(.MEM_WAIT(0)) dut0 (
        .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
        .branch_addr(branch_addr), .mem_addr(mem_addr0), .mem_inst(mem_inst0),
        .inst_valid(inst_valid0), .inst_out(inst_out0), .pc_out(pc_out0),
        .q_count(q_count0)
    );

    inst_fetch_ctrl #(.MEM_WAIT(3)) dut3 (
        .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
        .branch_addr(branch_addr), .mem_addr(mem_addr3), .mem_inst(mem_inst3),
        .inst_valid(inst_valid3), .inst_out(inst_out3), .pc_out(pc_out3),
        .q_count(q_count3)
    );

    // Reference model: queue held head-first as a shift list; a word is
    // captured once MEM_WAIT cycles have elapsed since fetch_pc last changed.
    int          mw [2] = '{0, 3};
    logic [31:0] m_fpc [2];
    int          m_age [2];
    int          m_cnt [2];
    logic [31:0] m_pc [2][2];
    logic [31:0] m_in [2][2];

    task automatic model_update(input int k);
        bit          do_pop, do_push;
        logic [31:0] word;
        if (rst) begin
            m_fpc[k] = 32'd0;
            m_age[k] = 0;
            m_cnt[k] = 0;
        end else if (branch_taken) begin
            m_fpc[k] = {branch_addr[31:2], 2'b00};
            m_age[k] = 0;
            m_cnt[k] = 0;
        end else begin
            do_pop  = (m_cnt[k] > 0) && !freeze;
            do_push = (m_age[k] >= mw[k]) && ((m_cnt[k] < 2) || do_pop);
            word    = rom(m_fpc[k]);
            if (do_pop) begin
                m_pc[k][0] = m_pc[k][1];
                m_in[k][0] = m_in[k][1];
                m_cnt[k]   = m_cnt[k] - 1;
            end
            if (do_push) begin
                m_pc[k][m_cnt[k]] = m_fpc[k];
                m_in[k][m_cnt[k]] = word;
                m_cnt[k]          = m_cnt[k] + 1;
                m_fpc[k]          = m_fpc[k] + 32'd4;
                m_age[k]          = 0;
            end else if (m_age[k] < 100) begin
                m_age[k] = m_age[k] + 1;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_dut(input int k, input logic v, input logic [31:0] io,
                             input logic [31:0] po, input logic [1:0] qc,
                             input logic [31:0] ma);
        logic        e_v;
        logic [31:0] e_io, e_po;
        e_v  = (m_cnt[k] > 0);
        e_io = e_v ? m_in[k][0] : 32'd0;
        e_po = e_v ? m_pc[k][0] + 32'd4 : 32'd0;
        chk($sformatf("d%0d.inst_valid", mw[k]), {31'd0, v}, {31'd0, e_v});
        chk($sformatf("d%0d.inst_out", mw[k]), io, e_io);
        chk($sformatf("d%0d.pc_out", mw[k]), po, e_po);
        chk($sformatf("d%0d.q_count", mw[k]), {30'd0, qc}, 32'(m_cnt[k]));
        chk($sformatf("d%0d.mem_addr", mw[k]), ma, m_fpc[k]);
    endtask

    task automatic step();
        @(posedge clk);
        model_update(0);
        model_update(1);
        #1;
        check_dut(0, inst_valid0, inst_out0, pc_out0, q_count0, mem_addr0);
        check_dut(1, inst_valid3, inst_out3, pc_out3, q_count3, mem_addr3);
    endtask

    initial begin
        logic [31:0] hold_inst, hold_pc;
        int          n;

        rst          = 1'b1;
        freeze       = 1'b0;
        branch_taken = 1'b0;
        branch_addr  = 32'd0;
        for (int k = 0; k < 2; k++) begin
            m_fpc[k] = 32'd0; m_age[k] = 0; m_cnt[k] = 0;
            for (int j = 0; j < 2; j++) begin
                m_pc[k][j] = 32'd0; m_in[k][j] = 32'd0;
            end
        end
        step();
        step();
        chk("reset.inst_valid", {31'd0, inst_valid0}, 32'd0);
        chk("reset.mem_addr", mem_addr0, 32'd0);
        chk("reset.pc_out", pc_out0, 32'd0);

        // Run from reset with a zero-wait memory
        rst = 1'b0;
        step();
        chk("run.first_valid", {31'd0, inst_valid0}, 32'd1);
        chk("run.first_inst", inst_out0, 32'hE492_3002);
        chk("run.pc_out_4", pc_out0, 32'd4);
        step();
        chk("run.pc_out_8", pc_out0, 32'd8);
        step();
        chk("run.pc_out_12", pc_out0, 32'd12);
        step();
        chk("run.pc_out_16", pc_out0, 32'd16);

        // Freeze for five cycles: queue fills and the head holds
        hold_inst = m_in[0][0];
        hold_pc   = m_pc[0][0];
        freeze    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("freeze.inst_stable", inst_out0, hold_inst);
            if (i >= 1) begin
                chk("freeze.q_full", {30'd0, q_count0}, 32'd2);
                chk("freeze.addr_hold", mem_addr0, hold_pc + 32'd8);
            end
        end
        freeze = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("release.pc_seq", pc_out0, hold_pc + 32'd4 + 32'(4 * i));
        end

        // Branch with the queue full
        freeze = 1'b1;
        step();
        step();
        freeze       = 1'b0;
        branch_taken = 1'b1;
        branch_addr  = 32'h0000_0043;
        step();
        branch_taken = 1'b0;
        chk("br.valid_low", {31'd0, inst_valid0}, 32'd0);
        chk("br.q_empty", {30'd0, q_count0}, 32'd0);
        chk("br.mem_addr", mem_addr0, 32'h0000_0040);
        step();
        chk("br.pc_out", pc_out0, 32'h0000_0044);

        // Branch and freeze together: branch wins
        freeze = 1'b1;
        step();
        step();
        branch_taken = 1'b1;
        branch_addr  = 32'h0000_0043;
        step();
        branch_taken = 1'b0;
        chk("brfz.valid_low", {31'd0, inst_valid0}, 32'd0);
        chk("brfz.q_empty", {30'd0, q_count0}, 32'd0);
        chk("brfz.mem_addr", mem_addr0, 32'h0000_0040);
        freeze = 1'b0;
        step();
        chk("brfz.pc_out", pc_out0, 32'h0000_0044);

        // MEM_WAIT = 3: branch latency and steady-state spacing
        branch_taken = 1'b1;
        branch_addr  = 32'h0000_1000;
        step();
        branch_taken = 1'b0;
        n = 1;
        while (!inst_valid3 && n < 20) begin
            step();
            n++;
        end
        chk("w3.branch_latency", 32'(n), 32'd5);
        chk("w3.target_pc", pc_out3, 32'h0000_1004);
        n = 0;
        do begin
            step();
            n++;
        end while (!inst_valid3 && n < 20);
        chk("w3.spacing", 32'(n), 32'd4);
        step();
        branch_taken = 1'b1;
        branch_addr  = 32'h0000_2000;
        step();
        branch_taken = 1'b0;
        n = 1;
        while (!inst_valid3 && n < 20) begin
            step();
            n++;
        end
        chk("w3.wait_branch_latency", 32'(n), 32'd5);

        // Wrap-around of fetch_pc
        branch_taken = 1'b1;
        branch_addr  = 32'hFFFF_FFFC;
        step();
        branch_taken = 1'b0;
        step();
        chk("wrap.pc_out_0", pc_out0, 32'h0000_0000);
        chk("wrap.valid", {31'd0, inst_valid0}, 32'd1);
        step();
        chk("wrap.pc_out_4", pc_out0, 32'h0000_0004);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            rst          = ($urandom_range(0, 99) < 2);
            freeze       = ($urandom_range(0, 99) < 35);
            branch_taken = ($urandom_range(0, 99) < 6);
            branch_addr  = $urandom;
            step();
        end

        // Reset overrides a same-cycle branch
        rst          = 1'b0;
        freeze       = 1'b0;
        branch_taken = 1'b0;
        for (int i = 0; i < 6; i++) step();
        rst          = 1'b1;
        branch_taken = 1'b1;
        branch_addr  = 32'h0000_0800;
        step();
        chk("rstbr.d0_valid", {31'd0, inst_valid0}, 32'd0);
        chk("rstbr.d0_inst", inst_out0, 32'd0);
        chk("rstbr.d0_pc", pc_out0, 32'd0);
        chk("rstbr.d0_q", {30'd0, q_count0}, 32'd0);
        chk("rstbr.d0_addr", mem_addr0, 32'd0);
        chk("rstbr.d3_addr", mem_addr3, 32'd0);
        chk("rstbr.d3_valid", {31'd0, inst_valid3}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
